// File: rtl/rawp_dma_writer.sv
// rawp_dma_writer: stream-to-memory DMA writer for the raw port of the
// capture RAM. It writes accepted 32-bit words to consecutive word
// addresses from a programmed base, in one-shot or ring mode, and reports
// progress (write pointer, committed word count, wrap/done pulses, error).
module rawp_dma_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = ADDR_WIDTH - 2
) (
  input  logic                  rawp_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [LEN_WIDTH-1:0]  cfg_len_i,
  input  logic                  cfg_ring_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ADDR_WIDTH-1:0] rawp_adr_o,
  output logic [31:0]           rawp_dat_o,
  output logic                  rawp_we_o,
  input  logic                  rawp_stall_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [LEN_WIDTH-1:0]  words_o,
  output logic                  wrap_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  ring_q, ring_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic                  we_q, we_d;
  logic                  we_dly_q, we_dly_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  err_hit;
  logic                  accept;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] start_base;

  // Back-pressure is combinational from the RAM stall flag and the stop request.
  always_comb begin
    s_ready_o = (state_q == ST_RUN) & ~rawp_stall_i & ~cfg_stop_i;
  end

  // Next-state logic: config latch, beat acceptance, pointer/count tracking, error abort.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    ring_d     = ring_q;
    idx_d      = idx_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = 1'b0;
    we_dly_d   = we_q;
    wr_ptr_d   = wr_ptr_q;
    words_d    = words_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_hit    = we_dly_q & rawp_stall_i;
    accept     = s_valid_i & s_ready_o;
    last_beat  = (idx_q == (len_q - LEN_WIDTH'(1)));
    start_base = {cfg_base_i[ADDR_WIDTH-1:2], 2'b00};

    if (we_dly_q && !rawp_stall_i && (words_q != '1)) begin
      words_d = words_q + LEN_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (err_hit) begin
          err_d = 1'b1;
        end
        if (cfg_start_i && !cfg_stop_i) begin
          base_d   = start_base;
          len_d    = cfg_len_i;
          ring_d   = cfg_ring_i;
          idx_d    = '0;
          wr_ptr_d = start_base;
          words_d  = '0;
          err_d    = 1'b0;
          if (cfg_len_i != '0) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cfg_stop_i) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          adr_d = wr_ptr_q;
          dat_d = s_dat_i;
          we_d  = 1'b1;
          if (last_beat && ring_q) begin
            idx_d    = '0;
            wr_ptr_d = base_q;
            wrap_d   = 1'b1;
          end else begin
            idx_d    = idx_q + LEN_WIDTH'(1);
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(4);
            if (last_beat) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled write aborts an active transfer and suppresses its pulses.
    if (err_hit && (state_q != ST_IDLE)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  // Register all state and outputs; reset returns to IDLE with every output cleared.
  always_ff @(posedge rawp_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      ring_q   <= 1'b0;
      idx_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      we_dly_q <= 1'b0;
      wr_ptr_q <= '0;
      words_q  <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      ring_q   <= ring_d;
      idx_q    <= idx_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      we_dly_q <= we_dly_d;
      wr_ptr_q <= wr_ptr_d;
      words_q  <= words_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rawp_adr_o = adr_q;
  assign rawp_dat_o = dat_q;
  assign rawp_we_o  = we_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign wr_ptr_o   = wr_ptr_q;
  assign words_o    = words_q;
  assign wrap_o     = wrap_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rawp_dma_writer.sv
// Directed testbench for rawp_dma_writer: one-shot, ring, gapped stream,
// stall error, zero length, stop, start-while-busy, address wrap and
// asynchronous reset, with hand-computed expectations.
module tb_rawp_dma_writer;

   logic        rawp_clk;
   logic        rst;
   logic [11:0] cfg_base_i;
   logic [9:0]  cfg_len_i;
   logic        cfg_ring_i;
   logic        cfg_start_i;
   logic        cfg_stop_i;
   logic [31:0] s_dat_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [11:0] rawp_adr_o;
   logic [31:0] rawp_dat_o;
   logic        rawp_we_o;
   logic        rawp_stall_i;
   logic        busy_o;
   logic [11:0] wr_ptr_o;
   logic [9:0]  words_o;
   logic        wrap_o;
   logic        done_o;
   logic        err_o;

   int          errors;
   int          checks;
   int          cycle;
   int          doneCount;
   int          doneCyc;
   int          wrapCount;
   logic [11:0] wrAdr[$];
   logic [31:0] wrDat[$];
   int          wrCyc[$];
   int          wrapCyc[$];
   int          wb;
   int          db;
   int          rb;

   rawp_dma_writer #(
      .ADDR_WIDTH(12),
      .LEN_WIDTH (10)
   ) dut (
      .rawp_clk    (rawp_clk),
      .rst         (rst),
      .cfg_base_i  (cfg_base_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_ring_i  (cfg_ring_i),
      .cfg_start_i (cfg_start_i),
      .cfg_stop_i  (cfg_stop_i),
      .s_dat_i     (s_dat_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .rawp_adr_o  (rawp_adr_o),
      .rawp_dat_o  (rawp_dat_o),
      .rawp_we_o   (rawp_we_o),
      .rawp_stall_i(rawp_stall_i),
      .busy_o      (busy_o),
      .wr_ptr_o    (wr_ptr_o),
      .words_o     (words_o),
      .wrap_o      (wrap_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
   initial begin
      rawp_clk = 1'b0;
      forever #5 rawp_clk = ~rawp_clk;
   end

   // Cycle counter so logged events can be related to each other in time.
   always @(posedge rawp_clk) begin
      cycle <= cycle + 1;
   end

   // Monitor on the falling edge: logs every RAM write and every done/wrap pulse.
   always @(negedge rawp_clk) begin
      if (!rst) begin
         if (rawp_we_o) begin
            wrAdr.push_back(rawp_adr_o);
            wrDat.push_back(rawp_dat_o);
            wrCyc.push_back(cycle);
         end
         if (done_o) begin
            doneCount = doneCount + 1;
            doneCyc   = cycle;
         end
         if (wrap_o) begin
            wrapCount = wrapCount + 1;
            wrapCyc.push_back(cycle);
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge rawp_clk);
      #1;
   endtask

   // Drive the stream, stall and stop inputs for the coming cycle.
   task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                input logic stall, input logic stop);
      s_valid_i    = valid;
      s_dat_i      = data;
      rawp_stall_i = stall;
      cfg_stop_i   = stop;
   endtask

   // Present a configuration with a one-cycle start pulse.
   task automatic doStart(input logic [11:0] base, input logic [9:0] len,
                          input logic ring);
      cfg_base_i  = base;
      cfg_len_i   = len;
      cfg_ring_i  = ring;
      cfg_start_i = 1'b1;
      step();
      cfg_start_i = 1'b0;
   endtask

   // One comparison: counts it, and on mismatch counts a failure and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks = checks + 1;
      assert (observed === expected)
      else begin
         errors = errors + 1;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Directed test sequence.
   initial begin
      errors       = 0;
      checks       = 0;
      cycle        = 0;
      doneCount    = 0;
      doneCyc      = 0;
      wrapCount    = 0;
      cfg_base_i   = '0;
      cfg_len_i    = '0;
      cfg_ring_i   = 1'b0;
      cfg_start_i  = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      #1 rst = 1'b1;
      #10;

      $display("[TB] reset values");
      checkOutput("rst_adr",    rawp_adr_o, 0);
      checkOutput("rst_dat",    rawp_dat_o, 0);
      checkOutput("rst_we",     rawp_we_o,  0);
      checkOutput("rst_busy",   busy_o,     0);
      checkOutput("rst_wrptr",  wr_ptr_o,   0);
      checkOutput("rst_words",  words_o,    0);
      checkOutput("rst_err",    err_o,      0);
      checkOutput("rst_done",   done_o,     0);
      checkOutput("rst_wrap",   wrap_o,     0);
      checkOutput("rst_ready",  s_ready_o,  0);
      step();
      rst = 1'b0;
      step();
      step();

      $display("[TB] one-shot base=0x100 len=4");
      wb = wrAdr.size();
      db = doneCount;
      doStart(12'h100, 10'd4, 1'b0);
      checkOutput("os_busy",  busy_o,    1);
      checkOutput("os_ready", s_ready_o, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hA0 + i, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checkOutput("os_done_pulse", done_o, 1);
      checkOutput("os_busy_end",   busy_o, 0);
      step();
      checkOutput("os_done_low", done_o, 0);
      checkOutput("os_nwr",      wrAdr.size() - wb, 4);
      checkOutput("os_adr0", wrAdr[wb],   12'h100);
      checkOutput("os_adr1", wrAdr[wb+1], 12'h104);
      checkOutput("os_adr2", wrAdr[wb+2], 12'h108);
      checkOutput("os_adr3", wrAdr[wb+3], 12'h10C);
      checkOutput("os_dat0", wrDat[wb],   32'hA0);
      checkOutput("os_dat3", wrDat[wb+3], 32'hA3);
      checkOutput("os_b2b",    wrCyc[wb+3] - wrCyc[wb], 3);
      checkOutput("os_ndone",  doneCount - db, 1);
      checkOutput("os_donecyc", doneCyc - wrCyc[wb+3], 1);
      checkOutput("os_words",  words_o,  4);
      checkOutput("os_wrptr",  wr_ptr_o, 12'h110);

      $display("[TB] ring base=0x0 len=3, 7 beats, then stop");
      wb = wrAdr.size();
      db = doneCount;
      rb = wrapCount;
      doStart(12'h000, 10'd3, 1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 32'hB0 + i, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      checkOutput("ring_nwr",  wrAdr.size() - wb, 7);
      checkOutput("ring_adr2", wrAdr[wb+2], 12'h008);
      checkOutput("ring_adr3", wrAdr[wb+3], 12'h000);
      checkOutput("ring_adr5", wrAdr[wb+5], 12'h008);
      checkOutput("ring_adr6", wrAdr[wb+6], 12'h000);
      checkOutput("ring_dat6", wrDat[wb+6], 32'hB6);
      checkOutput("ring_nwrap", wrapCount - rb, 2);
      checkOutput("ring_wrapcyc", wrapCyc[rb] - wrCyc[wb+2], 0);
      checkOutput("ring_ndone", doneCount - db, 0);
      checkOutput("ring_words", words_o,  7);
      checkOutput("ring_wrptr", wr_ptr_o, 12'h004);
      checkOutput("ring_busy",  busy_o,   1);
      applyStimulus(1'b1, 32'hBF, 1'b0, 1'b1);
      #1;
      checkOutput("stop_ready", s_ready_o, 0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checkOutput("stop_busy",  busy_o, 0);
      checkOutput("stop_nwr",   wrAdr.size() - wb, 7);
      checkOutput("stop_ndone", doneCount - db, 0);

      $display("[TB] gapped stream base=0x200 len=5");
      wb = wrAdr.size();
      db = doneCount;
      doStart(12'h200, 10'd5, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2) == 0, 32'hC0 + i, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      checkOutput("gap_nwr",  wrAdr.size() - wb, 5);
      checkOutput("gap_dat1", wrDat[wb+1], 32'hC2);
      checkOutput("gap_dat4", wrDat[wb+4], 32'hC8);
      checkOutput("gap_adr4", wrAdr[wb+4], 12'h210);
      checkOutput("gap_space", wrCyc[wb+1] - wrCyc[wb], 2);
      checkOutput("gap_ndone", doneCount - db, 1);
      checkOutput("gap_words", words_o, 5);

      $display("[TB] stall after second write");
      wb = wrAdr.size();
      db = doneCount;
      doStart(12'h300, 10'd8, 1'b0);
      applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 32'hD2, 1'b1, 1'b0);
      #1;
      checkOutput("err_ready_stall", s_ready_o, 0);
      step();
      applyStimulus(1'b1, 32'hD3, 1'b0, 1'b0);
      checkOutput("err_flag",  err_o,     1);
      checkOutput("err_busy",  busy_o,    0);
      checkOutput("err_ready", s_ready_o, 0);
      step();
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("err_nwr",   wrAdr.size() - wb, 2);
      checkOutput("err_ndone", doneCount - db, 0);
      checkOutput("err_words", words_o, 1);
      checkOutput("err_sticky", err_o, 1);

      $display("[TB] zero-length start clears error");
      doStart(12'h300, 10'd0, 1'b0);
      checkOutput("zl_done",  done_o, 1);
      checkOutput("zl_err",   err_o,  0);
      checkOutput("zl_busy",  busy_o, 0);
      step();
      checkOutput("zl_done_low", done_o, 0);
      checkOutput("zl_nwr",   wrAdr.size() - wb, 2);

      $display("[TB] start while busy is ignored");
      wb = wrAdr.size();
      db = doneCount;
      doStart(12'h400, 10'd4, 1'b0);
      applyStimulus(1'b1, 32'hE0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 32'hE1, 1'b0, 1'b0);
      step();
      cfg_base_i  = 12'h800;
      cfg_len_i   = 10'd2;
      cfg_start_i = 1'b1;
      applyStimulus(1'b1, 32'hE2, 1'b0, 1'b0);
      step();
      cfg_start_i = 1'b0;
      applyStimulus(1'b1, 32'hE3, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      step();
      checkOutput("sb_nwr",   wrAdr.size() - wb, 4);
      checkOutput("sb_adr2",  wrAdr[wb+2], 12'h408);
      checkOutput("sb_adr3",  wrAdr[wb+3], 12'h40C);
      checkOutput("sb_dat2",  wrDat[wb+2], 32'hE2);
      checkOutput("sb_ndone", doneCount - db, 1);
      checkOutput("sb_wrptr", wr_ptr_o, 12'h410);

      $display("[TB] address wrap base=0xFF8 len=4");
      wb = wrAdr.size();
      doStart(12'hFF8, 10'd4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hF0 + i, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      step();
      checkOutput("aw_adr0", wrAdr[wb],   12'hFF8);
      checkOutput("aw_adr1", wrAdr[wb+1], 12'hFFC);
      checkOutput("aw_adr2", wrAdr[wb+2], 12'h000);
      checkOutput("aw_adr3", wrAdr[wb+3], 12'h004);
      checkOutput("aw_wrptr", wr_ptr_o, 12'h008);

      $display("[TB] start and stop together in idle");
      db = doneCount;
      cfg_base_i  = 12'h600;
      cfg_len_i   = 10'd4;
      cfg_ring_i  = 1'b0;
      cfg_start_i = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      cfg_start_i = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("ss_busy",  busy_o,   0);
      checkOutput("ss_wrptr", wr_ptr_o, 12'h008);
      step();
      checkOutput("ss_ndone", doneCount - db, 0);

      $display("[TB] asynchronous reset mid-run");
      wb = wrAdr.size();
      doStart(12'h500, 10'd8, 1'b1);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
      step();
      step();
      #2 rst = 1'b1;
      #1;
      checkOutput("ar_we",    rawp_we_o,  0);
      checkOutput("ar_adr",   rawp_adr_o, 0);
      checkOutput("ar_dat",   rawp_dat_o, 0);
      checkOutput("ar_busy",  busy_o,     0);
      checkOutput("ar_wrptr", wr_ptr_o,   0);
      checkOutput("ar_words", words_o,    0);
      checkOutput("ar_ready", s_ready_o,  0);
      #2 rst = 1'b0;
      step();
      step();
      step();
      checkOutput("ar_nwr",  wrAdr.size() - wb, 1);
      checkOutput("ar_idle", busy_o, 0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
